// File: rtl/expr_stream_checker.sv
// expr_stream_checker
//
// Streaming syntax checker for ASCII arithmetic expressions. One character
// is consumed on every rising clk edge where in_valid is high. It accepts
// multi-digit operands, a configurable operator set, nested parentheses
// and optional space separators. The first bad character latches a sticky
// error together with its 0-based position.
//
// Ports:
//   clk      - rising-edge clock
//   clr      - asynchronous, active-high reset; discards the expression
//   in_valid - in carries a character this cycle
//   in       - ASCII character
//   out      - accepted characters form a complete, balanced, error-free
//              expression
//   err      - sticky error flag
//   err_pos  - index of the first offending character (0 while err=0)
//   depth    - current open-parenthesis count
module expr_stream_checker #(
  parameter int MAX_DEPTH     = 7,
  parameter int DEPTH_W       = 3,
  parameter int MAX_DIGITS    = 4,
  parameter int POS_W         = 8,
  parameter int ALLOW_SPACE   = 1,
  parameter int ALLOW_SUB_DIV = 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               out,
  output logic               err,
  output logic [POS_W-1:0]   err_pos,
  output logic [DEPTH_W-1:0] depth
);

  localparam int DIG_W = $clog2(MAX_DIGITS + 1);

  localparam logic [1:0] S_EXPECT = 2'd0;
  localparam logic [1:0] S_NUM    = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] S_ERR    = 2'd3;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
  localparam logic [DIG_W-1:0]   DIG_MAX   = DIG_W'(MAX_DIGITS);

  logic [1:0]         state, state_nxt;
  logic [DEPTH_W-1:0] depth_q, depth_nxt;
  logic [DIG_W-1:0]   dig_cnt, dig_cnt_nxt;
  logic [POS_W-1:0]   char_idx;
  logic [POS_W-1:0]   err_pos_q;

  logic is_digit, is_op, is_lpar, is_rpar, is_space;

  // Character classification. Anything that falls into none of these
  // classes is illegal in every state.
  always_comb begin
    is_digit = (in >= 8'h30) && (in <= 8'h39);
    is_op    = (in == 8'h2B) || (in == 8'h2A) ||
               ((ALLOW_SUB_DIV != 0) && ((in == 8'h2D) || (in == 8'h2F)));
    is_lpar  = (in == 8'h28);
    is_rpar  = (in == 8'h29);
    is_space = (ALLOW_SPACE != 0) && (in == 8'h20);
  end

  // Next-state logic. On any transition into S_ERR, depth and the digit
  // count keep their old values, so they show where the error happened.
  always_comb begin
    state_nxt   = state;
    depth_nxt   = depth_q;
    dig_cnt_nxt = dig_cnt;
    case (state)
      S_EXPECT: begin
        if (is_digit) begin
          state_nxt   = S_NUM;
          dig_cnt_nxt = DIG_W'(1);
        end else if (is_lpar) begin
          if (depth_q == DEPTH_MAX) state_nxt = S_ERR;
          else                      depth_nxt = depth_q + DEPTH_W'(1);
        end else if (!is_space) begin
          state_nxt = S_ERR;
        end
      end
      S_NUM: begin
        if (is_digit) begin
          if (dig_cnt == DIG_MAX) state_nxt   = S_ERR;
          else                    dig_cnt_nxt = dig_cnt + DIG_W'(1);
        end else if (is_op) begin
          state_nxt   = S_EXPECT;
          dig_cnt_nxt = '0;
        end else if (is_rpar) begin
          if (depth_q == '0) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt   = S_DONE;
            depth_nxt   = depth_q - DEPTH_W'(1);
            dig_cnt_nxt = '0;
          end
        end else if (is_space) begin
          state_nxt   = S_DONE;
          dig_cnt_nxt = '0;
        end else begin
          state_nxt = S_ERR;
        end
      end
      S_DONE: begin
        if (is_op) begin
          state_nxt = S_EXPECT;
        end else if (is_rpar) begin
          if (depth_q == '0) begin
            state_nxt = S_ERR;
          end else begin
            depth_nxt = depth_q - DEPTH_W'(1);
          end
        end else if (!is_space) begin
          state_nxt = S_ERR;
        end
      end
      default: begin
        state_nxt = S_ERR;
      end
    endcase
  end

  // State registers. The character index saturates rather than wrapping.
  // This keeps err_pos meaningful for very long streams. err_pos captures
  // the index of the character that causes the entry into S_ERR.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= S_EXPECT;
      depth_q   <= '0;
      dig_cnt   <= '0;
      char_idx  <= '0;
      err_pos_q <= '0;
    end else if (in_valid) begin
      state   <= state_nxt;
      depth_q <= depth_nxt;
      dig_cnt <= dig_cnt_nxt;
      if (char_idx != '1) char_idx <= char_idx + POS_W'(1);
      if ((state_nxt == S_ERR) && (state != S_ERR)) err_pos_q <= char_idx;
    end
  end

  // Outputs are decoded directly from the registers.
  always_comb begin
    err     = (state == S_ERR);
    out     = ((state == S_NUM) || (state == S_DONE)) && (depth_q == '0) && !err;
    depth   = depth_q;
    err_pos = err_pos_q;
  end

endmodule
